ascon_ad_absorber: RTL and testbench
====================================

// Module: ascon_ad_absorber
// PURPOSE
//  Sequential ASCON associated-data absorber for an arbitrary number of AD blocks.
//  Sits between initialisation and plaintext processing. Takes the 320-bit state and streams AD blocks over a valid/ready handshake.
//  Handles padding, the extra pad-only block and the empty-AD case.
//  Outputs the state after domain separation (x4 ^= 1). The permutation runs iteratively, UNROLL rounds per cycle.
// PARAMETERS
//  RATE      64  rate in bits; 64 (ASCON-128) or 128 (ASCON-128a); rate = x0, or x0||x1
//  ROUNDS_B  6   rounds of pB; 6 or 8; round index i runs 12-ROUNDS_B..11
//  UNROLL    1   rounds per clock; 1, 2 or 3; must divide ROUNDS_B
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async reset, active low
//  start        in   1        load state_in; ignored unless busy=0
//  no_ad        in   1        sampled with start: AD empty, skip absorption
//  state_in     in   320      {x0,x1,x2,x3,x4}, x0 at [319:256]
//  ad_valid     in   1        AD beat valid
//  ad_ready     out  1        AD beat accepted when ad_valid & ad_ready
//  ad_data      in   RATE     AD block; byte 0 at [RATE-1:RATE-8]
//  ad_last      in   1        final AD beat
//  ad_bytes     in   $clog2(RATE/8+1)  valid bytes in the last beat (0..RATE/8); ignored when !ad_last
//  busy         out  1        high in every state except IDLE
//  out_valid    out  1        state_out valid
//  out_ready    in   1        consumer accepts state_out
//  state_out    out  320      absorbed and domain-separated state, held while out_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE. ad_ready=0, busy=0, out_valid=0, state_out=0, round counter=0, need_pad=0.
//  FSM states: IDLE, WAIT_AD, PERM, DONE.
//  IDLE, start=1:
//   - no_ad=0: S<=state_in; go to WAIT_AD.
//   - no_ad=1: S<=state_in with x4^=1; go to DONE.
//  WAIT_AD: ad_ready=1. On a handshake:
//   - rate ^= blk; rc<=0; go to PERM.
//   - Non-last beat: blk=ad_data.
//   - Last beat, ad_bytes=k<RATE/8: blk = ad_data with bytes >=k forced to 0, and byte k = 0x80.
//   - Last beat, k=RATE/8: blk=ad_data; need_pad<=1.
//   - Latch ad_last.
//  PERM: ad_ready=0. Each cycle applies UNROLL rounds. Round constant for round i = {4'hF-i, i[3:0]}.
//   Action at the final round edge (rc = ROUNDS_B/UNROLL-1):
//   - !last: go to WAIT_AD.
//   - last & need_pad: rate ^= 0x80 followed by zeros, in the same edge; need_pad<=0; rc<=0; stay in PERM.
//   - last & !need_pad: x4 ^= 64'h1 in the same edge; go to DONE.
//  DONE: out_valid=1; state_out=S, stable. On out_ready: go to IDLE; out_valid drops next cycle.
//  start while busy=1: ignored. ad_valid outside WAIT_AD: not accepted.
//  Latency per block: 1 accept cycle + ROUNDS_B/UNROLL round cycles. Pad-only block: ROUNDS_B/UNROLL cycles.
//  RATE=128: blk[127:64] XORs into x0 and blk[63:0] into x1. Byte k is counted across the whole 128-bit block.
//  rst_n asserted mid-operation: immediate return to IDLE with all outputs 0. A partial absorption is discarded.
//  Back-to-back operation: out_ready and start in the same cycle in DONE -> go to IDLE; start is not taken until the next cycle.
// STRUCTURE
//  Package ascon_pkg holds:
//   - typedef ascon_state_t (5 x 64-bit words)
//   - function rc(i)
//   - constants PAD_BYTE=8'h80 and DSEP=64'h1
//   - function pad_block(data,k)
//  Sub-module ascon_round: one combinational round (constant addition, S-box layer, linear layer). Ports: state in/out, 8-bit rc.
//  UNROLL instances of ascon_round are chained in this block, with rc derived from the round counter.
// TESTING
//  1. RATE=64, ROUNDS_B=6, UNROLL=1. Start, then 3 beats with ad_valid held high; last beat k=8.
//     -> 4 permutations; out_valid rises 28 cycles after the start edge.
//     -> state_out matches the software model (3 blocks + pad block + x4^1).
//  2. Same config, 3 beats; last beat k=7 with ad_data[7:0]=8'h80.
//     -> state_out equals the golden chain of three p6 calls with plain XOR and x4^=1; no pad block.
//  3. start with no_ad=1, state_in=S0.
//     -> out_valid the next cycle; state_out = S0 ^ {256'h0,64'h1}; ad_ready never high.
//  4. RATE=128, ROUNDS_B=8, UNROLL=2. One last beat with k=0.
//     -> block XOR is x0^=64'h8000_0000_0000_0000, x1 unchanged.
//     -> 4 round cycles; output matches the model.
//  5. ad_valid toggled randomly and out_ready held low for 10 cycles.
//     -> no beat lost or duplicated; state_out stable; start ignored while busy.
//  6. rst_n pulled low during PERM, then released, then a new job started.
//     -> outputs 0 at once; the new job's result matches the model, unaffected by the aborted job.

Source files
------------

// File: rtl/ascon_pkg.sv
// ASCON shared types and helpers.
// State words are x0..x4, with x0 in the most significant bits.
package ascon_pkg;

  typedef logic [0:4][63:0] ascon_state_t;

  localparam logic [7:0]  PAD_BYTE = 8'h80;
  localparam logic [63:0] DSEP     = 64'h1;

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  // Block is MSB-aligned in 128 bits, so byte j sits at [127-8j -: 8].
  // Bytes below k are kept, byte k becomes the pad byte, the rest are zeroed.
  function automatic logic [127:0] pad_block(
    input logic [127:0] data,
    input logic [4:0]   k
  );
    logic [127:0] b;
    b = '0;
    for (int j = 0; j < 16; j++) begin
      if (5'(j) < k)
        b[127-8*j -: 8] = data[127-8*j -: 8];
      else if (5'(j) == k)
        b[127-8*j -: 8] = PAD_BYTE;
    end
    return b;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round.
// Applies constant addition, the S-box layer and the linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state,
  input  logic [7:0]   rcon,
  output ascon_state_t next
);

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int          n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

  ascon_state_t x;
  logic [0:4][63:0] t;

  always_comb begin
    x = state;
    x[2] = x[2] ^ {56'h0, rcon};
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int i = 0; i < 5; i++)
      t[i] = ~x[i] & x[(i+1)%5];
    for (int i = 0; i < 5; i++)
      x[i] = x[i] ^ t[(i+1)%5];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    next[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
    next[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
    next[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
    next[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
    next[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
  end

endmodule

// File: rtl/ascon_ad_absorber.sv
// ASCON associated-data absorber with an iterative pB permutation.
// Handles padding, the pad-only block, the empty-AD case and domain separation.
module ascon_ad_absorber
  import ascon_pkg::*;
#(
  parameter int RATE     = 64,
  parameter int ROUNDS_B = 6,
  parameter int UNROLL   = 1
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         no_ad,
  input  logic [319:0]                 state_in,
  input  logic                         ad_valid,
  output logic                         ad_ready,
  input  logic [RATE-1:0]              ad_data,
  input  logic                         ad_last,
  input  logic [$clog2(RATE/8+1)-1:0]  ad_bytes,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [319:0]                 state_out
);

  localparam int NB   = RATE / 8;
  localparam int NCYC = ROUNDS_B / UNROLL;
  localparam int CW   = $clog2(NCYC + 1);

  typedef enum logic [1:0] {IDLE, WAIT_AD, PERM, DONE} st_t;

  st_t           st;
  ascon_state_t  s;
  logic [CW-1:0] rcnt;
  logic          last;
  logic          need_pad;

  ascon_state_t  chain [UNROLL+1];
  ascon_state_t  pn;
  ascon_state_t  absorbed;
  ascon_state_t  padded;
  ascon_state_t  sep;
  logic [127:0]  raw;
  logic [127:0]  blk;
  logic          full;

  assign chain[0] = s;

  for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
    logic [3:0] idx;
    logic [7:0] rcv;
    assign idx = 4'(12 - ROUNDS_B + u) + 4'(int'(rcnt) * UNROLL);
    assign rcv = rc(idx);
    ascon_round u_round (
      .state (chain[u]),
      .rcon  (rcv),
      .next  (chain[u+1])
    );
  end

  assign pn = chain[UNROLL];
  assign full = int'(ad_bytes) == NB;

  always_comb begin
    raw = '0;
    raw[127 -: RATE] = ad_data;
    blk = ad_last ? pad_block(raw, 5'(ad_bytes)) : raw;
    absorbed = s;
    absorbed[0] = s[0] ^ blk[127:64];
    absorbed[1] = s[1] ^ ((RATE == 128) ? blk[63:0] : 64'h0);
    padded = pn;
    padded[0] = pn[0] ^ {PAD_BYTE, 56'h0};
    sep = pn;
    sep[4] = pn[4] ^ DSEP;
  end

  assign state_out = s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      s         <= '0;
      rcnt      <= '0;
      last      <= 1'b0;
      need_pad  <= 1'b0;
      ad_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (no_ad) begin
              s         <= {state_in[319:64], state_in[63:0] ^ DSEP};
              st        <= DONE;
              out_valid <= 1'b1;
            end else begin
              s        <= state_in;
              st       <= WAIT_AD;
              ad_ready <= 1'b1;
            end
          end
        end
        WAIT_AD: begin
          if (ad_valid && ad_ready) begin
            s        <= absorbed;
            rcnt     <= '0;
            last     <= ad_last;
            need_pad <= ad_last && full;
            ad_ready <= 1'b0;
            st       <= PERM;
          end
        end
        PERM: begin
          if (rcnt == CW'(NCYC - 1)) begin
            rcnt <= '0;
            if (!last) begin
              s        <= pn;
              ad_ready <= 1'b1;
              st       <= WAIT_AD;
            end else if (need_pad) begin
              s        <= padded;
              need_pad <= 1'b0;
            end else begin
              s         <= sep;
              out_valid <= 1'b1;
              st        <= DONE;
            end
          end else begin
            s    <= pn;
            rcnt <= rcnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_ad_absorber.sv
// Self-checking bench for ascon_ad_absorber.
// Covers RATE=64/p6/x1 and RATE=128/p8/x2 against a software model.
module tb_ascon_ad_absorber;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_start, a_no_ad, a_ad_valid, a_ad_ready, a_ad_last;
  logic         a_busy, a_out_valid, a_out_ready;
  logic [319:0] a_state_in, a_state_out;
  logic [63:0]  a_ad_data;
  logic [3:0]   a_ad_bytes;

  logic         b_start, b_no_ad, b_ad_valid, b_ad_ready, b_ad_last;
  logic         b_busy, b_out_valid, b_out_ready;
  logic [319:0] b_state_in, b_state_out;
  logic [127:0] b_ad_data;
  logic [4:0]   b_ad_bytes;

  ascon_ad_absorber #(.RATE(64), .ROUNDS_B(6), .UNROLL(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .no_ad(a_no_ad),
    .state_in(a_state_in), .ad_valid(a_ad_valid), .ad_ready(a_ad_ready),
    .ad_data(a_ad_data), .ad_last(a_ad_last), .ad_bytes(a_ad_bytes),
    .busy(a_busy), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .state_out(a_state_out)
  );

  ascon_ad_absorber #(.RATE(128), .ROUNDS_B(8), .UNROLL(2)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .no_ad(b_no_ad),
    .state_in(b_state_in), .ad_valid(b_ad_valid), .ad_ready(b_ad_ready),
    .ad_data(b_ad_data), .ad_last(b_ad_last), .ad_bytes(b_ad_bytes),
    .busy(b_busy), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .state_out(b_state_out)
  );

  int nchk = 0;
  int nerr = 0;
  logic [319:0] sbq[$];

  typedef struct {
    bit           no_ad;
    int           nb;
    int           k;
    bit           rnd;
    int           hold;
    int           cyc;
    logic [319:0] s0;
    logic [63:0]  ad [4];
    logic [319:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [319:0] act,
                     input logic [319:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int i);
    logic [63:0] a, b, c, d, e, t0, t1, t2, t3, t4;
    {a, b, c, d, e} = s;
    c = c ^ {56'h0, 4'(15 - i), 4'(i)};
    a = a ^ e; e = e ^ d; c = c ^ b;
    t0 = ~a & b; t1 = ~b & c; t2 = ~c & d; t3 = ~d & e; t4 = ~e & a;
    a = a ^ t1; b = b ^ t2; c = c ^ t3; d = d ^ t4; e = e ^ t0;
    b = b ^ a; a = a ^ e; d = d ^ c; c = ~c;
    a = a ^ ror(a, 19) ^ ror(a, 28);
    b = b ^ ror(b, 61) ^ ror(b, 39);
    c = c ^ ror(c, 1)  ^ ror(c, 6);
    d = d ^ ror(d, 10) ^ ror(d, 17);
    e = e ^ ror(e, 7)  ^ ror(e, 41);
    return {a, b, c, d, e};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
    for (int i = 12 - nr; i < 12; i++) s = m_round(s, i);
    return s;
  endfunction

  function automatic logic [319:0] m_absorb64(input logic [319:0] s,
      input logic [63:0] ad [4], input int nb, input int k, input bit no_ad);
    logic [63:0] blk;
    if (!no_ad) begin
      for (int b = 0; b < nb; b++) begin
        blk = ad[b];
        if (b == nb - 1 && k < 8)
          blk = (blk & ~({64{1'b1}} >> (8 * k))) | (64'h80 << (56 - 8 * k));
        s[319:256] = s[319:256] ^ blk;
        s = m_perm(s, 6);
      end
      if (k == 8) begin
        s[319:256] = s[319:256] ^ (64'h80 << 56);
        s = m_perm(s, 6);
      end
    end
    s[63:0] = s[63:0] ^ 64'h1;
    return s;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_beat(input vec_t v, input int beat);
    a_ad_valid = (beat < v.nb) && (!v.rnd || ($urandom % 2 == 1));
    a_ad_data  = '0;
    if (beat < v.nb) a_ad_data = v.ad[beat];
    a_ad_last  = (beat == v.nb - 1);
    a_ad_bytes = 4'(v.k);
  endtask

  task automatic run64(input vec_t v);
    int n, beat;
    bit hs, rdy_seen, done, stable;
    logic [319:0] held;
    sbq.push_back(v.exp);
    a_state_in = v.s0;
    a_no_ad = v.no_ad;
    a_start = 1'b1;
    beat = 0; n = 0; rdy_seen = 0; done = 0;
    drive_beat(v, beat);
    while (n < 300 && !done) begin
      hs = a_ad_valid && a_ad_ready;
      if (a_ad_ready) rdy_seen = 1;
      @(posedge clk); #1;
      n++;
      if (hs) beat++;
      if (a_out_valid) begin
        done = 1;
        a_start = 1'b0;
        a_ad_valid = 1'b0;
      end else begin
        a_start = v.rnd && ($urandom % 4 == 0);
        a_no_ad = 1'b1;
        a_state_in = rnd320();
        drive_beat(v, beat);
      end
    end
    if (!done) begin
      chk_int("timeout64", n, -1);
      void'(sbq.pop_front());
      return;
    end
    chk("result64", a_state_out, sbq.pop_front());
    if (!v.rnd) chk_int("latency64", n, v.cyc);
    chk_int("beats64", beat, v.nb);
    if (v.no_ad) chk_int("ready_seen", int'(rdy_seen), 0);
    held = a_state_out;
    stable = 1;
    repeat (v.hold) begin
      @(posedge clk); #1;
      if (a_state_out !== held || !a_out_valid) stable = 0;
    end
    if (v.hold > 0) chk_int("held64", int'(stable), 1);
    a_out_ready = 1'b1;
    a_start = 1'b1;
    a_no_ad = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_start = 1'b0;
    chk_int("idle64", int'({a_busy, a_out_valid}), 0);
  endtask

  task automatic run128(input int k);
    logic [319:0] s0, e;
    logic [127:0] d, blk;
    int n;
    bit hs;
    s0 = rnd320();
    d = {$urandom, $urandom, $urandom, $urandom};
    blk = d;
    if (k < 16)
      blk = (d & ~({128{1'b1}} >> (8 * k))) | (128'h80 << (120 - 8 * k));
    e = s0;
    e[319:192] = e[319:192] ^ blk;
    e = m_perm(e, 8);
    if (k == 16) begin
      e[319:256] = e[319:256] ^ (64'h80 << 56);
      e = m_perm(e, 8);
    end
    e[63:0] = e[63:0] ^ 64'h1;
    sbq.push_back(e);
    b_state_in = s0; b_no_ad = 1'b0; b_start = 1'b1;
    b_ad_valid = 1'b1; b_ad_last = 1'b1; b_ad_bytes = 5'(k); b_ad_data = d;
    n = 0;
    while (n < 100 && !b_out_valid) begin
      hs = b_ad_valid && b_ad_ready;
      @(posedge clk); #1;
      n++;
      b_start = 1'b0;
      if (hs) b_ad_valid = 1'b0;
    end
    if (!b_out_valid) begin
      chk_int("timeout128", n, -1);
      void'(sbq.pop_front());
      return;
    end
    chk("result128", b_state_out, sbq.pop_front());
    chk_int("latency128", n, (k == 16) ? 10 : 6);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  initial begin
    logic [319:0] s;
    a_start = 0; a_no_ad = 0; a_ad_valid = 0; a_ad_last = 0;
    a_out_ready = 0; a_state_in = '0; a_ad_data = '0; a_ad_bytes = '0;
    b_start = 0; b_no_ad = 0; b_ad_valid = 0; b_ad_last = 0;
    b_out_ready = 0; b_state_in = '0; b_ad_data = '0; b_ad_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset64", {a_state_out, a_ad_ready, a_busy, a_out_valid}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      vecs[i].s0 = rnd320();
      for (int j = 0; j < 4; j++) vecs[i].ad[j] = {$urandom, $urandom};
      vecs[i].no_ad = 0; vecs[i].rnd = 0; vecs[i].hold = 0; vecs[i].cyc = 0;
    end
    vecs[0].nb = 3; vecs[0].k = 8; vecs[0].cyc = 28; vecs[0].hold = 2;
    vecs[1].nb = 3; vecs[1].k = 7; vecs[1].cyc = 22;
    vecs[1].ad[2][7:0] = 8'h80;
    vecs[2].nb = 0; vecs[2].k = 0; vecs[2].cyc = 1; vecs[2].no_ad = 1;
    vecs[3].nb = 4; vecs[3].k = 3; vecs[3].rnd = 1; vecs[3].hold = 10;
    vecs[4].nb = 1; vecs[4].k = 0; vecs[4].cyc = 8;
    vecs[5].nb = 2; vecs[5].k = 5; vecs[5].rnd = 1; vecs[5].hold = 3;
    vecs[6].nb = 2; vecs[6].k = 8; vecs[6].rnd = 1;
    for (int i = 0; i < 7; i++)
      vecs[i].exp = m_absorb64(vecs[i].s0, vecs[i].ad, vecs[i].nb,
                               vecs[i].k, vecs[i].no_ad);
    s = vecs[1].s0;
    for (int b = 0; b < 3; b++) begin
      s[319:256] = s[319:256] ^ vecs[1].ad[b];
      s = m_perm(s, 6);
    end
    s[63:0] = s[63:0] ^ 64'h1;
    vecs[1].exp = s;
    vecs[2].exp = vecs[2].s0 ^ {256'h0, 64'h1};

    for (int i = 0; i < 7; i++) run64(vecs[i]);

    a_state_in = rnd320(); a_no_ad = 1'b0; a_start = 1'b1;
    a_ad_valid = 1'b1; a_ad_last = 1'b0; a_ad_data = {$urandom, $urandom};
    repeat (4) begin
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort64", {a_state_out, a_ad_ready, a_busy, a_out_valid}, '0);
    a_ad_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run64(vecs[0]);
    run64(vecs[5]);

    run128(0);
    run128(9);
    run128(16);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
